// File: rtl/imm_gen_pipe_if.sv
// Handshake and result bus between fetch, the pipelined immediate generator and execute.
// Producer drives the in_* request side; the generator (slave) drives in_ready and out_*.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: combinational decode into a 2-entry registered output queue.
// Optional macro IMMGEN_ZICSR_EN: CSR immediate forms (opcode 73, funct3[2]=1) report fmt 6 with zimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  imm_gen_pipe_if.slave       bus,
  output logic [15:0]         illegal_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  localparam logic [1:0]  CNT_FULL = 2'd2;
  localparam logic [15:0] CNT_SAT  = 16'hFFFF;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] ins;
  logic [2:0]  fmt_c;
  logic        ill_c;
  entry_t      dec_c;
  entry_t      head_q;
  entry_t      tail_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        push_c;
  logic        pop_c;

  assign ins = bus.in_instr;

  // Opcode classification; illegal encodings fall through as R with the illegal flag set
  always_comb begin
    fmt_c = FMT_R;
    ill_c = 1'b0;
    if (ins[1:0] != 2'b11) begin
      ill_c = 1'b1;
    end else begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: fmt_c = FMT_I;
        7'h73: begin
`ifdef IMMGEN_ZICSR_EN
          fmt_c = ins[14] ? FMT_Z : FMT_I;
`else
          fmt_c = FMT_I;
`endif
        end
        7'h23:        fmt_c = FMT_S;
        7'h63:        fmt_c = FMT_B;
        7'h37, 7'h17: fmt_c = FMT_U;
        7'h6F:        fmt_c = FMT_J;
        7'h33, 7'h0F: fmt_c = FMT_R;
        7'h1B: begin
          if (XLEN == 64) fmt_c = FMT_I;
          else            ill_c = 1'b1;
        end
        7'h3B: begin
          if (XLEN != 64) ill_c = 1'b1;
        end
        default:      ill_c = 1'b1;
      endcase
    end
  end

  // Immediate assembly; every signed form extends from instr[31]
  always_comb begin
    dec_c         = '0;
    dec_c.fmt     = fmt_c;
    dec_c.illegal = ill_c;
    dec_c.tag     = bus.in_tag;
    case (fmt_c)
      FMT_I:   dec_c.imm = XLEN'($signed(ins[31:20]));
      FMT_S:   dec_c.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      FMT_B:   dec_c.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      FMT_U:   dec_c.imm = XLEN'($signed({ins[31:12], 12'h000}));
      FMT_J:   dec_c.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      FMT_Z:   dec_c.imm = XLEN'(ins[19:15]);
      default: dec_c.imm = '0;
    endcase
  end

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Head always feeds out_*; tail only holds the second entry while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d != CNT_FULL);
      out_valid_q <= (cnt_d != 2'd0);
      if (push_c && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_c))) begin
        head_q <= dec_c;
      end else if (pop_c && (cnt_q == CNT_FULL)) begin
        head_q <= tail_q;
      end
      if (push_c && (cnt_q == 2'd1) && !pop_c) begin
        tail_q <= dec_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= 16'h0000;
    end else if (push_c && ill_c && (illegal_cnt != CNT_SAT)) begin
      illegal_cnt <= illegal_cnt + 16'h0001;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_illegal = head_q.illegal;
  assign bus.out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep against a queue model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();
  logic [15:0] ic32;
  logic [15:0] ic64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave), .illegal_cnt(ic32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave), .illegal_cnt(ic64));

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  tag;
  } txn_t;

  txn_t        q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [15:0] mcnt32 = 16'h0;
  logic [15:0] mcnt64 = 16'h0;
  logic [6:0]  ops [13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h0F, 7'h1B, 7'h3B};

  // Reference decode from the ISA field layout, using signed integer arithmetic
  function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v;
    longint top;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    top = i[31] ? -64'sd1 : 64'sd0;
    if (i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (i[6:0])
        7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = longint'($signed(i)) >>> 20; end
        7'h1B: begin
          if (x64) begin fmt = 3'd1; v = longint'($signed(i)) >>> 20; end
          else ill = 1'b1;
        end
        7'h73: begin
`ifdef IMMGEN_ZICSR_EN
          if (i[14]) begin fmt = 3'd6; v = longint'(i[19:15]); end
          else begin fmt = 3'd1; v = longint'($signed(i)) >>> 20; end
`else
          fmt = 3'd1; v = longint'($signed(i)) >>> 20;
`endif
        end
        7'h23: begin fmt = 3'd2; v = (longint'($signed(i)) >>> 25) * 32 + longint'(i[11:7]); end
        7'h63: begin
          fmt = 3'd3;
          v = top * 4096 + 2048 * longint'(i[7]) + 32 * longint'(i[30:25]) + 2 * longint'(i[11:8]);
        end
        7'h37, 7'h17: begin fmt = 3'd4; v = (longint'($signed(i)) >>> 12) * 4096; end
        7'h6F: begin
          fmt = 3'd5;
          v = top * 1048576 + 4096 * longint'(i[19:12]) + 2048 * longint'(i[20]) + 2 * longint'(i[30:21]);
        end
        7'h33, 7'h0F: fmt = 3'd0;
        7'h3B: if (!x64) ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end
    imm = x64 ? 64'(v) : {32'h0, 32'(v)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  // Compare both instances with the model queue head and counters
  task automatic check_state();
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    chk("in_ready32",  64'(b32.in_ready),  64'(q.size() != 2));
    chk("in_ready64",  64'(b64.in_ready),  64'(q.size() != 2));
    chk("out_valid32", 64'(b32.out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(b64.out_valid), 64'(q.size() != 0));
    chk("illcnt32", 64'(ic32), 64'(mcnt32));
    chk("illcnt64", 64'(ic64), 64'(mcnt64));
    if (q.size() != 0) begin
      ref_dec(q[0].ins, 1'b0, imm, fmt, ill);
      chk("imm32", 64'(b32.out_imm), imm);
      chk("fmt32", 64'(b32.out_fmt), 64'(fmt));
      chk("ill32", 64'(b32.out_illegal), 64'(ill));
      chk("tag32", 64'(b32.out_tag), 64'(q[0].tag));
      ref_dec(q[0].ins, 1'b1, imm, fmt, ill);
      chk("imm64", 64'(b64.out_imm), imm);
      chk("fmt64", 64'(b64.out_fmt), 64'(fmt));
      chk("ill64", 64'(b64.out_illegal), 64'(ill));
      chk("tag64", 64'(b64.out_tag), 64'(q[0].tag));
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [4:0] tg, input bit ordy);
    b32.in_valid = v;  b32.in_instr = ins; b32.in_tag = tg; b32.out_ready = ordy;
    b64.in_valid = v;  b64.in_instr = ins; b64.in_tag = tg; b64.out_ready = ordy;
  endtask

  // One clock: drive at negedge, check pre-edge state, then advance the model across the edge
  task automatic step(input bit v, input logic [31:0] ins, input logic [4:0] tg,
                      input bit ordy, input bit do_chk);
    bit          push;
    bit          pop;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    txn_t        t;
    @(negedge clk);
    drive(v, ins, tg, ordy);
    if (do_chk) check_state();
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      t.ins = ins;
      t.tag = tg;
      q.push_back(t);
      ref_dec(ins, 1'b0, imm, fmt, ill);
      if (ill && mcnt32 != 16'hFFFF) mcnt32++;
      ref_dec(ins, 1'b1, imm, fmt, ill);
      if (ill && mcnt64 != 16'hFFFF) mcnt64++;
    end
    #1 drive(1'b0, 32'h0, 5'h0, 1'b0);
  endtask

  task automatic head_const(input string nm, input logic [63:0] imm64, input logic [2:0] fmt);
    @(negedge clk);
    chk({nm, "_imm32"}, 64'(b32.out_imm), {32'h0, imm64[31:0]});
    chk({nm, "_imm64"}, 64'(b64.out_imm), imm64);
    chk({nm, "_fmt"},   64'(b32.out_fmt), 64'(fmt));
  endtask

  initial begin
    logic [31:0] ins;
    drive(1'b0, 32'h0, 5'h0, 1'b0);
    #12;
    chk("rst_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_imm",   64'(b64.out_imm), 64'd0);
    chk("rst_fmt",   64'(b64.out_fmt), 64'd0);
    chk("rst_ill",   64'(b32.out_illegal), 64'd0);
    chk("rst_tag",   64'(b32.out_tag), 64'd0);
    chk("rst_cnt",   64'(ic32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values from the decode tables
    step(1'b1, 32'hFFF00093, 5'd3, 1'b1, 1'b1);
    head_const("addi", 64'hFFFFFFFFFFFFFFFF, 3'd1);
    chk("addi_tag", 64'(b32.out_tag), 64'd3);
    chk("addi_ill", 64'(b32.out_illegal), 64'd0);
    step(1'b1, 32'hFE112E23, 5'd4, 1'b1, 1'b1);
    head_const("sw", 64'hFFFFFFFFFFFFFFFC, 3'd2);
    step(1'b1, 32'hFE000CE3, 5'd5, 1'b1, 1'b1);
    head_const("beq", 64'hFFFFFFFFFFFFFFF8, 3'd3);
    step(1'b1, 32'h0000006F, 5'd6, 1'b1, 1'b1);
    head_const("jal", 64'h0, 3'd5);
    step(1'b1, 32'h800002B7, 5'd7, 1'b1, 1'b1);
    head_const("lui", 64'hFFFFFFFF80000000, 3'd4);
    step(1'b1, 32'h3002D073, 5'd8, 1'b1, 1'b1);
`ifdef IMMGEN_ZICSR_EN
    head_const("csrrwi", 64'h5, 3'd6);
`else
    head_const("csrrwi", 64'h300, 3'd1);
`endif
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h0, 5'(k), 1'b1, 1'b1);
      head_const("zero", 64'h0, 3'd0);
      chk("zero_ill", 64'(b32.out_illegal), 64'd1);
    end
    chk("zero_cnt32", 64'(ic32), 64'd3);
    chk("zero_cnt64", 64'(ic64), 64'd3);
    step(1'b1, 32'hFFF0009B, 5'd9, 1'b1, 1'b1);
    step(1'b1, 32'h0000003B, 5'd10, 1'b1, 1'b1);

    // Backpressure: third push held off until the queue drains
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    step(1'b1, 32'h00500113, 5'd11, 1'b0, 1'b1);
    step(1'b1, 32'h00A00193, 5'd12, 1'b0, 1'b1);
    step(1'b1, 32'h00F00213, 5'd13, 1'b0, 1'b1);
    step(1'b1, 32'h00F00213, 5'd13, 1'b1, 1'b1);
    step(1'b1, 32'h00F00213, 5'd13, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);

    // Random traffic over legal and illegal opcodes with random stalls
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
      step(1'(($urandom_range(0, 3)) != 0), ins, 5'($urandom), 1'(($urandom_range(0, 2)) != 0), 1'b1);
    end
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);

    // Saturation of the illegal counter
    while (mcnt64 != 16'hFFFF || mcnt32 != 16'hFFFF) step(1'b1, 32'h0, 5'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0, 5'd2, 1'b1, 1'b1);
    step(1'b1, 32'h0, 5'd2, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    chk("sat32", 64'(ic32), 64'hFFFF);
    chk("sat64", 64'(ic64), 64'hFFFF);

    // Asynchronous reset with the queue full
    step(1'b1, 32'h00100093, 5'd14, 1'b0, 1'b1);
    step(1'b1, 32'h00200093, 5'd15, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_ready", 64'(b32.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(b32.out_valid), 64'd0);
    chk("arst_ready", 64'(b64.in_ready), 64'd1);
    chk("arst_imm",   64'(b64.out_imm), 64'd0);
    chk("arst_cnt",   64'(ic32), 64'd0);
    q.delete();
    mcnt32 = 16'h0;
    mcnt64 = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 5'd3, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the combinational immediate generator in the decode path. It accepts one 32-bit RV instruction per cycle over a valid/ready handshake. For each instruction it extracts and sign-extends the immediate to XLEN bits, classifies the instruction format and flags illegal opcodes. Results are buffered in a 2-entry output queue so that stalls from the execute stage do not create a combinational ready path back into fetch.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 5, width of the sideband tag carried alongside each instruction (PC index or ROB id).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result at the queue head is valid.
- out_ready  in  1  consumer accepts the head.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the head entry.
- illegal_cnt  out  16  saturating count of accepted illegal instructions.

## Operation
- Decode is combinational on in_instr. The result is written to the queue tail on a push (in_valid & in_ready).
- Opcode-to-format mapping (instr[6:0]):
  - I: 03, 13, 67, 73.
  - S: 23.
  - B: 63.
  - U: 37, 17.
  - J: 6F.
  - R/none: 33, 0F.
  - When XLEN=64, additionally 1B is I and 3B is R.
- Immediate bit selection is per standard RV encoding.
- Sign bit is always instr[31]. Every format, U included, is sign-extended to XLEN.
- B and J immediates have bit 0 forced to 0. U immediates have the low 12 bits zero.
- R/none format yields imm = 0.
- Illegal condition: instr[1:0] != 2'b11, or opcode not in the map above.
  - Result: out_illegal=1, fmt=0, imm=0.
  - illegal_cnt increments on the push and saturates at 0xFFFF.
- Queue:
  - 2 entries; count register 0..2.
  - in_ready = (count != 2). It depends only on registered state, never on out_ready.
  - out_valid = (count != 0). out_* present the head entry.
  - Pop = out_valid & out_ready.
  - Push and pop in the same cycle at count 1: count stays 1, and the new entry becomes the head after the edge.
  - At count 2, a push cannot occur.
- Payload of an entry is never altered while it is queued.

## Timing
- Latency: instruction pushed at edge N appears on out_* with out_valid=1 immediately after edge N. Zero added cycles in the uncongested case, one registered stage.
- Throughput: 1 per cycle while out_ready=1.
- in_ready falls after the second unpopped push. It rises in the cycle after a pop from full.
- Reset values:
  - count=0, so out_valid=0 and in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - illegal_cnt=0.
- Reset asserted mid-operation discards queued entries immediately and asynchronously. The first push is possible on the first edge after rst_n deasserts.
- in_instr and in_tag are sampled only on a push edge. Values presented while in_ready=0 are ignored.

## Configuration
- IMMGEN_ZICSR_EN defined:
  - opcode 73 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) yields fmt=6.
  - imm is instr[19:15] zero-extended to XLEN.
  - Other 73 instructions remain I.
- Not defined: all opcode 73 instructions are I-type with sign-extended instr[31:20].

## Test plan
- Single push: XLEN=32, push 0xFFF00093 (addi x1,x0,-1) with tag 3, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1, out_tag=3, out_illegal=0.
- Back-to-back formats: push 0xFE112E23, then 0xFE000CE3, then 0x0000006F -> in order:
  - 0xFFFFFFFC, fmt 2.
  - 0xFFFFFFF8, fmt 3.
  - 0x00000000, fmt 5.
- XLEN=64 U-type: push 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=4.
- CSR immediate: push 0x3002D073 (csrrwi x0,mstatus,5) -> with IMMGEN_ZICSR_EN out_imm=5, fmt=6; without, out_imm=0x300, fmt=1.
- Illegal instructions: push 0x00000000 three times -> out_illegal=1 and out_imm=0 each time; illegal_cnt=3. Force the counter to 0xFFFF and push another illegal -> stays 0xFFFF.
- Backpressure and reset:
  - out_ready=0 with 3 consecutive in_valid cycles -> in_ready=0 after the 2nd push; the 3rd instruction is held off.
  - Raise out_ready -> entries drain in order, then the 3rd is accepted.
  - Assert rst_n=0 with count=2 -> out_valid=0 and in_ready=1 with no clock edge.
